// File: rtl/dphy_hs_lane_tx.sv
// rtl/dphy_hs_lane_tx.sv - single-lane D-PHY HS transmit sequencer and dibit serializer
// Outputs are flops loaded from the next-state decode, so they track state/phase/shifter exactly.
module dphy_hs_lane_tx #(
    parameter int T_LPX      = 8,
    parameter int T_HS_PREP  = 8,
    parameter int T_HS_ZERO  = 16,
    parameter int T_HS_TRAIL = 12,
    parameter int T_HS_EXIT  = 16
) (
    input  logic       dphy_clk,
    input  logic       areset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic [1:0] hs_dout,
    output logic       hs_oe,
    output logic [1:0] lp_dout,
    output logic       busy,
    output logic       underrun
);

    typedef enum logic [2:0] {
        S_IDLE, S_LPX, S_PREP, S_ZERO, S_SYNC, S_DATA, S_TRAIL, S_EXIT
    } state_t;

    localparam logic [7:0] LPX_END   = 8'(T_LPX - 1);
    localparam logic [7:0] PREP_END  = 8'(T_HS_PREP - 1);
    localparam logic [7:0] ZERO_END  = 8'(T_HS_ZERO - 1);
    localparam logic [7:0] TRAIL_END = 8'(T_HS_TRAIL - 1);
    localparam logic [7:0] EXIT_END  = 8'(T_HS_EXIT - 1);
    localparam logic [7:0] PHASE_END = 8'd3;
    localparam logic [7:0] SYNC_BYTE = 8'hB8;

    state_t     state, state_nx;
    logic [7:0] cnt, cnt_nx;
    logic [7:0] shifter, shift_nx;
    logic       last_acc, last_nx;
    logic       trail_bit, tbit_nx;
    logic       und_nx, ready_nx, oe_nx, busy_nx;
    logic [1:0] hs_nx, lp_nx;
    logic [7:0] hs_byte;
    logic       accept;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 8'd1;
        shift_nx = shifter;
        last_nx  = last_acc;
        tbit_nx  = trail_bit;
        und_nx   = 1'b0;
        accept   = tx_ready && tx_valid;
        case (state)
            S_IDLE: begin
                cnt_nx = '0;
                if (tx_valid) state_nx = S_LPX;
            end
            S_LPX: if (cnt == LPX_END) begin
                state_nx = S_PREP;
                cnt_nx   = '0;
            end
            S_PREP: if (cnt == PREP_END) begin
                state_nx = S_ZERO;
                cnt_nx   = '0;
            end
            S_ZERO: if (cnt == ZERO_END) begin
                state_nx = S_SYNC;
                cnt_nx   = '0;
                last_nx  = 1'b0;
            end
            S_SYNC, S_DATA: if (cnt == PHASE_END) begin
                cnt_nx = '0;
                if (accept) begin
                    state_nx = S_DATA;
                    shift_nx = tx_data;
                    last_nx  = tx_last;
                end else begin
                    // Ready point without a byte is an underrun; after tx_last ready is low so no pulse.
                    state_nx = S_TRAIL;
                    tbit_nx  = (state == S_DATA) ? shifter[7] : 1'b0;
                    und_nx   = tx_ready;
                end
            end
            S_TRAIL: if (cnt == TRAIL_END) begin
                state_nx = S_EXIT;
                cnt_nx   = '0;
            end
            S_EXIT: if (cnt == EXIT_END) begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase

        hs_byte  = (state_nx == S_SYNC) ? SYNC_BYTE : shift_nx;
        ready_nx = (cnt_nx == PHASE_END) &&
                   ((state_nx == S_SYNC) || ((state_nx == S_DATA) && !last_nx));
        busy_nx  = (state_nx != S_IDLE);
        oe_nx    = 1'b0;
        hs_nx    = 2'b00;
        lp_nx    = 2'b00;
        case (state_nx)
            S_IDLE, S_EXIT: lp_nx = 2'b11;
            S_LPX:          lp_nx = 2'b01;
            S_PREP:         lp_nx = 2'b00;
            S_ZERO:         oe_nx = 1'b1;
            S_SYNC, S_DATA: begin
                oe_nx = 1'b1;
                hs_nx = hs_byte[{cnt_nx[1:0], 1'b0} +: 2];
            end
            S_TRAIL: begin
                oe_nx = 1'b1;
                hs_nx = {~tbit_nx, ~tbit_nx};
            end
            default: lp_nx = 2'b11;
        endcase
    end

    always_ff @(posedge dphy_clk or posedge areset) begin
        if (areset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            shifter   <= '0;
            last_acc  <= 1'b0;
            trail_bit <= 1'b0;
            tx_ready  <= 1'b0;
            hs_dout   <= 2'b00;
            hs_oe     <= 1'b0;
            lp_dout   <= 2'b11;
            busy      <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            shifter   <= shift_nx;
            last_acc  <= last_nx;
            trail_bit <= tbit_nx;
            tx_ready  <= ready_nx;
            hs_dout   <= hs_nx;
            hs_oe     <= oe_nx;
            lp_dout   <= lp_nx;
            busy      <= busy_nx;
            underrun  <= und_nx;
        end
    end

endmodule

// File: tb/tb_dphy_hs_lane_tx.sv
// tb/tb_dphy_hs_lane_tx.sv - directed scoreboard bench for dphy_hs_lane_tx
module tb_dphy_hs_lane_tx;

    localparam int P_LPX   = 2;
    localparam int P_PREP  = 2;
    localparam int P_ZERO  = 3;
    localparam int P_TRAIL = 3;
    localparam int P_EXIT  = 3;

    logic       dphy_clk = 1'b0;
    logic       areset = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_last = 1'b0;
    logic       tx_ready;
    logic [1:0] hs_dout;
    logic       hs_oe;
    logic [1:0] lp_dout;
    logic       busy;
    logic       underrun;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0] lp;
        logic       oe;
        logic [1:0] hs;
        logic       rdy;
        logic       bsy;
        logic       und;
        int         idx;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] bq[$];

    dphy_hs_lane_tx #(
        .T_LPX(P_LPX), .T_HS_PREP(P_PREP), .T_HS_ZERO(P_ZERO),
        .T_HS_TRAIL(P_TRAIL), .T_HS_EXIT(P_EXIT)
    ) dut (
        .dphy_clk(dphy_clk), .areset(areset), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_last(tx_last), .tx_ready(tx_ready), .hs_dout(hs_dout), .hs_oe(hs_oe),
        .lp_dout(lp_dout), .busy(busy), .underrun(underrun)
    );

    always #5 dphy_clk = ~dphy_clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge dphy_clk);
        @(negedge dphy_clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " lp"}, 8'(lp_dout), 8'h3);
        chk({tag, " oe"}, 8'(hs_oe), 8'h0);
        chk({tag, " hs"}, 8'(hs_dout), 8'h0);
        chk({tag, " rdy"}, 8'(tx_ready), 8'h0);
        chk({tag, " busy"}, 8'(busy), 8'h0);
        chk({tag, " und"}, 8'(underrun), 8'h0);
    endtask

    task automatic push(input logic [1:0] lp, input logic oe, input logic [1:0] hs,
                        input logic rdy, input logic bsy, input logic und, input int idx);
        exp_t e;
        e.lp = lp; e.oe = oe; e.hs = hs; e.rdy = rdy; e.bsy = bsy; e.und = und; e.idx = idx;
        sb.push_back(e);
    endtask

    function automatic logic [1:0] dib(input logic [7:0] b, input int p);
        logic [7:0] t;
        t = b >> (2 * p);
        return t[1:0];
    endfunction

    // Bytes come from bq. drop: index of byte withheld at its ready point (-1 none).
    // abort: expected-cycle index at which areset is pulsed mid-cycle (-1 none).
    task automatic burst(input string name, input int drop, input int abort);
        int n, sent, j;
        logic b, rdy;
        exp_t e;
        string tag;
        n = bq.size();
        sent = (drop < 0) ? n : drop;
        sb.delete();
        for (int i = 0; i < P_LPX; i++)  push(2'b01, 0, 2'b00, 0, 1, 0, -1);
        for (int i = 0; i < P_PREP; i++) push(2'b00, 0, 2'b00, 0, 1, 0, -1);
        for (int i = 0; i < P_ZERO; i++) push(2'b00, 1, 2'b00, 0, 1, 0, -1);
        for (int p = 0; p < 4; p++) push(2'b00, 1, dib(8'hB8, p), p == 3, 1, 0, (p == 3) ? 0 : -1);
        for (int i = 0; i < sent; i++) begin
            for (int p = 0; p < 4; p++) begin
                rdy = (p == 3) && !(drop < 0 && i == n - 1);
                push(2'b00, 1, dib(bq[i], p), rdy, 1, 0, rdy ? i + 1 : -1);
            end
        end
        b = (sent > 0) ? bq[sent - 1][7] : 1'b0;
        for (int i = 0; i < P_TRAIL; i++)
            push(2'b00, 1, b ? 2'b00 : 2'b11, 0, 1, (i == 0) && (drop >= 0), -1);
        for (int i = 0; i < P_EXIT; i++) push(2'b11, 0, 2'b00, 0, 1, 0, -1);
        push(2'b11, 0, 2'b00, 0, 0, 0, -1);

        tx_valid = 1'b1;
        tx_data  = 8'($urandom);
        tx_last  = 1'b0;
        j = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            tick();
            tag = $sformatf("%s[%0d]", name, j);
            chk({tag, " lp"}, 8'(lp_dout), 8'(e.lp));
            chk({tag, " oe"}, 8'(hs_oe), 8'(e.oe));
            chk({tag, " hs"}, 8'(hs_dout), 8'(e.hs));
            chk({tag, " rdy"}, 8'(tx_ready), 8'(e.rdy));
            chk({tag, " busy"}, 8'(busy), 8'(e.bsy));
            chk({tag, " und"}, 8'(underrun), 8'(e.und));
            if (j == abort) begin
                #2 areset = 1'b1;
                #1 chk_idle({tag, " async_rst"});
                tx_valid = 1'b0;
                @(negedge dphy_clk);
                chk_idle({tag, " rst_held"});
                areset = 1'b0;
                tick();
                chk_idle({tag, " rst_rel"});
                sb.delete();
                return;
            end
            if (e.idx >= 0) begin
                tx_valid = (e.idx != drop);
                tx_data  = bq[e.idx];
                tx_last  = (e.idx == n - 1);
            end else if (sb.size() == 0) begin
                tx_valid = 1'b0;
            end else begin
                tx_valid = 1'b1;
                tx_data  = 8'($urandom);
                tx_last  = 1'($urandom);
            end
            j++;
        end
        tick();
        chk_idle({name, " stays_idle"});
    endtask

    initial begin
        repeat (2) @(negedge dphy_clk);
        #2 areset = 1'b1;
        #1 chk_idle("reset_async");
        @(negedge dphy_clk);
        areset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle($sformatf("reset_idle%0d", i));
        end

        bq = {8'h5A};               burst("single_5a", -1, -1);
        bq = {8'hFF, 8'h00};        burst("b2b_ff_00", -1, -1);
        bq = {8'h80};               burst("trail_80", -1, -1);
        bq = {8'hC3, 8'h11};        burst("underrun_data", 1, -1);
        bq = {8'h3C};               burst("underrun_sync", 0, -1);
        bq = {8'hA5, 8'h5A};        burst("abort_data", -1, P_LPX + P_PREP + P_ZERO + 4 + 2);
        bq = {8'h96, 8'h69, 8'hE1}; burst("post_reset", -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
